// File: rtl/shift_sat_monitor.sv
// shift_sat_monitor: clamps the shifted sample to full scale when the shift
// stage flags overflow. It also counts clamped samples per fixed window of
// valid samples and keeps a sticky overflow flag for debug readout.
module shift_sat_monitor #(
    parameter int    DATA_WIDTH  = 16,
    parameter string DATA_TYPE   = "signed",
    parameter int    WINDOW_LEN  = 1024,
    parameter int    COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  din,
    input  logic                   din_valid,
    input  logic [1:0]             warning,
    input  logic                   clear,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   dout_valid,
    output logic [COUNT_WIDTH-1:0] ovf_count,
    output logic                   ovf_count_valid,
    output logic                   sticky_ovf
);

    localparam bit IS_SIGNED = (DATA_TYPE == "signed");
    localparam int WIN_W     = $clog2(WINDOW_LEN);

    localparam logic [WIN_W-1:0]      WIN_LAST = WIN_W'(WINDOW_LEN - 1);
    localparam logic [DATA_WIDTH-1:0] POS_MAX  = IS_SIGNED ? {1'b0, {(DATA_WIDTH-1){1'b1}}}
                                                           : {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] NEG_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

    logic                   sat_pos, sat_neg, sat_evt;
    logic [DATA_WIDTH-1:0]  dsat;

    logic [DATA_WIDTH-1:0]  dout_q, dout_d;
    logic                   dout_valid_q;
    logic [WIN_W-1:0]       win_q, win_d;
    logic [COUNT_WIDTH-1:0] run_q, run_d;
    logic [COUNT_WIDTH-1:0] ovf_count_q, ovf_count_d;
    logic                   ovf_pulse_q, ovf_pulse_d;
    logic                   sticky_q, sticky_d;

    // Decode the warning; in signed mode a both-bits-set warning clamps positive.
    always_comb begin
        sat_pos = 1'b0;
        sat_neg = 1'b0;
        if (IS_SIGNED) begin
            sat_pos = warning[0];
            sat_neg = warning[1] & ~warning[0];
        end else begin
            sat_pos = |warning;
        end
        sat_evt = din_valid & (sat_pos | sat_neg);
        dsat    = din;
        if (sat_pos)      dsat = POS_MAX;
        else if (sat_neg) dsat = NEG_MIN;
    end

    // Next state for data path, window counter, running count and sticky flag.
    always_comb begin
        logic [WIN_W-1:0]       win_base;
        logic [COUNT_WIDTH-1:0] run_base, run_inc;
        dout_d      = din_valid ? dsat : dout_q;
        // clear restarts the window so the sample in this cycle is its first.
        win_base    = clear ? '0 : win_q;
        run_base    = clear ? '0 : run_q;
        run_inc     = (sat_evt && run_base != CNT_MAX) ? run_base + 1'b1 : run_base;
        win_d       = win_base;
        run_d       = run_base;
        ovf_count_d = ovf_count_q;
        ovf_pulse_d = 1'b0;
        if (din_valid) begin
            if (win_base == WIN_LAST) begin
                // Closing sample: its own sat event belongs to this window.
                win_d       = '0;
                run_d       = '0;
                ovf_count_d = run_inc;
                ovf_pulse_d = 1'b1;
            end else begin
                win_d = win_base + 1'b1;
                run_d = run_inc;
            end
        end
        // Set beats clear so a coincident event is never lost.
        sticky_d = sat_evt | (sticky_q & ~clear);
    end

    // State registers; everything drops to zero on reset, discarding a partial window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            win_q        <= '0;
            run_q        <= '0;
            ovf_count_q  <= '0;
            ovf_pulse_q  <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= din_valid;
            win_q        <= win_d;
            run_q        <= run_d;
            ovf_count_q  <= ovf_count_d;
            ovf_pulse_q  <= ovf_pulse_d;
            sticky_q     <= sticky_d;
        end
    end

    assign dout            = dout_q;
    assign dout_valid      = dout_valid_q;
    assign ovf_count       = ovf_count_q;
    assign ovf_count_valid = ovf_pulse_q;
    assign sticky_ovf      = sticky_q;

endmodule

// File: doc/shift_sat_monitor.md
Name: shift_sat_monitor

Overview:
- Sits directly downstream of the parametrized bit-shift stage.
- Consumes the shifted sample and its 2-bit overflow warning, and clamps the sample to full scale when a warning is flagged. Without this stage, the wrapped value would propagate.
- Also counts clamped samples over a fixed window of valid samples, and keeps a sticky overflow flag for software/debug readout.

Parameters:
- DATA_WIDTH, 16: sample width; must match the upstream shift stage.
- DATA_TYPE, "signed": "signed" or "unsigned"; selects the saturation limits and the warning decode.
- WINDOW_LEN, 1024: number of valid samples per measurement window; must be ≥2.
- COUNT_WIDTH, 16: width of the overflow counters.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- din  in  DATA_WIDTH  shifted sample from the shift stage.
- din_valid  in  1  qualifies din and warning.
- warning  in  2  overflow flags from the shift stage:
  - signed: [0] = positive overflow, [1] = negative overflow.
  - unsigned: any nonzero value = overflow.
- clear  in  1  synchronous clear; restarts the window and clears the sticky flag.
- dout  out  DATA_WIDTH  saturated sample.
- dout_valid  out  1  qualifies dout.
- ovf_count  out  COUNT_WIDTH  number of saturated samples in the last completed window.
- ovf_count_valid  out  1  one-cycle pulse when ovf_count updates.
- sticky_ovf  out  1  set on any saturation; held until clear.

Behaviour:
- Reset (rst_n=0, asynchronous): all of the following are 0 immediately:
  - dout, dout_valid, ovf_count, ovf_count_valid, sticky_ovf;
  - the internal window counter and the running count.
- Latency: one clock, fully registered.
  - dout_valid(n+1) = din_valid(n).
  - dout is updated only when din_valid=1; otherwise it holds its previous value.
- There is no backpressure; a sample can be accepted every cycle.
- Saturation, signed mode:
  - warning[0]=1 → dout = 2^(DATA_WIDTH-1)-1.
  - warning[1]=1 → dout = -2^(DATA_WIDTH-1).
  - Both bits set (illegal) → treated as positive saturation.
  - warning=0 → dout = din.
- Saturation, unsigned mode:
  - warning≠0 → dout = all ones.
  - warning=0 → dout = din.
- A "sat event" is din_valid=1 with the warning decoding as overflow; warning is ignored when din_valid=0.
- Window counter:
  - Range 0..WINDOW_LEN-1; increments on each din_valid.
  - Running count increments on each sat event and saturates at 2^COUNT_WIDTH-1 (no wrap).
- Window close: occurs on the valid sample that moves the window counter from WINDOW_LEN-1 back to 0.
  - That sample's sat event is included in the window being closed.
  - ovf_count <= final running count, and ovf_count_valid pulses high for exactly one cycle, aligned with that sample's dout_valid.
  - The running count restarts at 0 on the same edge.
- ovf_count holds its value between window closes.
- sticky_ovf: set on a sat event; cleared by clear. If clear and a sat event occur in the same cycle, set wins, so the event is not lost.
- clear:
  - Zeroes the window counter and the running count on the next edge.
  - The sample accepted in that cycle is the first sample of the new window; a sat event on it counts as 1.
  - ovf_count holds; no ovf_count_valid pulse is generated by clear.
  - The data path (dout/dout_valid) is unaffected.
- Reset mid-window: partial window discarded; no pulse is emitted.

Test Plan (DATA_WIDTH=16, signed, WINDOW_LEN=8, COUNT_WIDTH=4 unless stated):
- Pass-through and latency: din=0x1234, warning=0, valid for 1 cycle → next cycle dout=0x1234, dout_valid=1, sticky_ovf=0.
- Signed clamp:
  - warning=01 → dout=0x7FFF.
  - warning=10 → dout=0x8000.
  - warning=11 → dout=0x7FFF.
  - sticky_ovf=1 after the first of these.
- Unsigned mode: warning=01 with din=0x0ABC → dout=0xFFFF; warning=0 → dout=din.
- Window: 8 valid samples with sat on samples 2, 5 and 8 → single ovf_count_valid pulse with ovf_count=3, aligned with dout_valid of sample 8. The next window of 8 clean samples → ovf_count=0.
- Counter saturation: WINDOW_LEN=32, COUNT_WIDTH=4, 20 sat events in the window → ovf_count=15.
- Clear and reset:
  - clear asserted with a simultaneous sat event after 3 samples → sticky_ovf stays 1, window restarts. The next pulse arrives 8 samples after the clear cycle, including it, with count=1 plus later events.
  - rst_n pulsed low mid-window → all outputs 0 asynchronously, and no pulse until 8 fresh valid samples.
